dram_port_arbiter: RTL and testbench

Shares the single-port data RAM between the D-fetch stage (reads) and the writeback stage (writes) of the pipeline, and zero-fills the RAM after every reset. It sits between the two stages and the DRAM macro. It resolves same-cycle conflicts with alternating priority and forwards write data on same-address collisions. It holds both requesters off until the clear sweep completes.

---
 rtl/dram_port_arbiter_if.sv | 32 +++
 rtl/dram_port_arbiter.sv | 107 ++++++++++
 tb/tb_dram_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_port_arbiter_if.sv
// Request/grant bundle between the fetch and writeback stages,
// the arbiter and the single-port data RAM macro.
interface dram_port_arbiter_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
);
  logic               f_ce;
  logic [A_WIDTH-1:0] f_a;
  logic [D_WIDTH-1:0] f_d;
  logic               f_stall;
  logic               w_we;
  logic [A_WIDTH-1:0] w_a;
  logic [D_WIDTH-1:0] w_d;
  logic               w_stall;
  logic               m_ce;
  logic               m_we;
  logic [A_WIDTH-1:0] m_a;
  logic [D_WIDTH-1:0] m_wd;
  logic [D_WIDTH-1:0] m_rd;

  modport master (
    output f_ce, f_a, w_we, w_a, w_d, m_rd,
    input  f_d, f_stall, w_stall,
    input  m_ce, m_we, m_a, m_wd
  );

  modport slave (
    input  f_ce, f_a, w_we, w_a, w_d, m_rd,
    output f_d, f_stall, w_stall,
    output m_ce, m_we, m_a, m_wd
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Data RAM port arbiter: fetch reads vs writeback writes,
// alternating priority on conflicts, zero-fill sweep after reset.
module dram_port_arbiter #(
  parameter int A_WIDTH        = 12,
  parameter int D_WIDTH        = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  dram_port_arbiter_if.slave bus,
  output logic               ready
);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [A_WIDTH-1:0] clr_ptr;
  logic               fetch_owed;
  logic               owed_nxt;
  logic               both;
  logic               same;

  assign both = bus.f_ce && bus.w_we;
  assign same = (bus.f_a == bus.w_a);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_ptr    <= '0;
      fetch_owed <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_owed <= owed_nxt;
      ready      <= (state_nxt == S_RUN);
      if (state == S_CLEAR)
        clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    owed_nxt    = fetch_owed;
    bus.m_ce    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_a     = bus.f_a;
    bus.m_wd    = '0;
    bus.f_d     = '0;
    bus.f_stall = 1'b0;
    bus.w_stall = 1'b0;
    priority case (1'b1)
      reset: begin
        bus.f_stall = 1'b1;
        bus.w_stall = 1'b1;
      end
      (state == S_CLEAR): begin
        bus.m_ce    = 1'b1;
        bus.m_we    = 1'b1;
        bus.m_a     = clr_ptr;
        bus.f_stall = 1'b1;
        bus.w_stall = 1'b1;
        if (&clr_ptr)
          state_nxt = S_RUN;
      end
      // same-address collision: write wins, read is forwarded
      (both && same): begin
        bus.m_ce = 1'b1;
        bus.m_we = 1'b1;
        bus.m_a  = bus.w_a;
        bus.m_wd = bus.w_d;
        bus.f_d  = bus.w_d;
        owed_nxt = 1'b0;
      end
      (both && !fetch_owed): begin
        bus.m_ce    = 1'b1;
        bus.m_we    = 1'b1;
        bus.m_a     = bus.w_a;
        bus.m_wd    = bus.w_d;
        bus.f_stall = 1'b1;
        owed_nxt    = 1'b1;
      end
      both: begin
        bus.m_ce    = 1'b1;
        bus.f_d     = bus.m_rd;
        bus.w_stall = 1'b1;
        owed_nxt    = 1'b0;
      end
      bus.w_we: begin
        bus.m_ce = 1'b1;
        bus.m_we = 1'b1;
        bus.m_a  = bus.w_a;
        bus.m_wd = bus.w_d;
      end
      bus.f_ce: begin
        bus.m_ce = 1'b1;
        bus.f_d  = bus.m_rd;
        owed_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomized bench for dram_port_arbiter against a grant/RAM
// reference model, with a behavioural RAM macro.
module tb_dram_port_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic ready;

  always #5 clk = ~clk;

  dram_port_arbiter_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  dram_port_arbiter #(
    .A_WIDTH(AW),
    .D_WIDTH(DW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .ready(ready)
  );

  logic [DW-1:0] ram [DEPTH];
  assign bus.m_rd = ram[bus.m_a];
  always @(posedge clk)
    if (bus.m_ce && bus.m_we) ram[bus.m_a] <= bus.m_wd;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            f_waiting;
  int            n_tests;
  int            n_fail;
  logic [DW-1:0] obs_fd;
  bit            obs_fs;
  bit            obs_ws;
  int            f_run;
  int            w_run;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // One RUN cycle: predict grants from the arbitration rules
  task automatic run_cycle(output bit fg, output bit wg);
    bit            conflict;
    logic [DW-1:0] efd;
    @(negedge clk);
    conflict = bus.f_ce && bus.w_we && (bus.f_a != bus.w_a);
    wg = bus.w_we && !(conflict && f_waiting);
    fg = bus.f_ce && !(conflict && !f_waiting);
    if (!fg) efd = '0;
    else if (wg && bus.w_a == bus.f_a) efd = bus.w_d;
    else efd = ref_mem[bus.f_a];
    obs_fd = bus.f_d;
    obs_fs = bus.f_stall;
    obs_ws = bus.w_stall;
    check("f_stall", 32'(bus.f_stall), 32'(bus.f_ce && !fg));
    check("w_stall", 32'(bus.w_stall), 32'(bus.w_we && !wg));
    check("f_d", 32'(bus.f_d), 32'(efd));
    check("m_we", 32'(bus.m_we), 32'(wg));
    check("ready", 32'(ready), 32'd1);
    f_run = bus.f_stall ? f_run + 1 : 0;
    w_run = bus.w_stall ? w_run + 1 : 0;
    check("f_starve", 32'(f_run > 1), 32'd0);
    check("w_starve", 32'(w_run > 1), 32'd0);
    if (wg) ref_mem[bus.w_a] = bus.w_d;
    f_waiting = bus.f_ce && !fg;
    @(posedge clk);
    #1;
  endtask

  // Called right after reset deasserts: expect the 16-cycle sweep
  task automatic sweep_check();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clr_we", 32'(bus.m_we), 32'd1);
      check("clr_a", 32'(bus.m_a), 32'(i));
      check("clr_wd", 32'(bus.m_wd), 32'd0);
      check("clr_fs", 32'(bus.f_stall), 32'd1);
      check("clr_ws", 32'(bus.w_stall), 32'd1);
      check("clr_fd", 32'(bus.f_d), 32'd0);
      check("clr_rdy", 32'(ready), 32'd0);
    end
    bus.f_ce = 1'b0;
    bus.w_we = 1'b0;
    @(negedge clk);
    check("rdy_up", 32'(ready), 32'd1);
    check("idle_ce", 32'(bus.m_ce), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("zero", 32'(ram[i]), 32'd0);
      ref_mem[i] = '0;
    end
    f_waiting = 1'b0;
    f_run = 0;
    w_run = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit fg;
    bit wg;
    n_tests = 0;
    n_fail  = 0;
    f_run   = 0;
    w_run   = 0;
    reset    = 1'b1;
    bus.f_ce = 1'b1;
    bus.f_a  = 4'd3;
    bus.w_we = 1'b1;
    bus.w_a  = 4'd4;
    bus.w_d  = 8'h77;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom_range(1, 255));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ce", 32'(bus.m_ce), 32'd0);
    check("rst_we", 32'(bus.m_we), 32'd0);
    check("rst_fs", 32'(bus.f_stall), 32'd1);
    check("rst_ws", 32'(bus.w_stall), 32'd1);
    check("rst_rdy", 32'(ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep_check();

    // write RAM[5]=3C, then read it back
    bus.w_we = 1'b1; bus.w_a = 4'd5; bus.w_d = 8'h3C;
    run_cycle(fg, wg);
    bus.w_we = 1'b0;
    bus.f_ce = 1'b1; bus.f_a = 4'd5;
    run_cycle(fg, wg);
    check("rd5", 32'(obs_fd), 32'h3C);
    check("rd5_fs", 32'(obs_fs), 32'd0);

    // conflict: write first, then read
    bus.f_a = 4'd2;
    bus.w_we = 1'b1; bus.w_a = 4'd7; bus.w_d = 8'h11;
    run_cycle(fg, wg);
    check("cf1_fs", 32'(obs_fs), 32'd1);
    check("cf1_ws", 32'(obs_ws), 32'd0);
    bus.w_we = 1'b0;
    run_cycle(fg, wg);
    check("cf2_fs", 32'(obs_fs), 32'd0);
    check("cf2_fd", 32'(obs_fd), 32'd0);

    // continuous conflict: W,R,W,R,W,R
    bus.f_a = 4'd1;
    bus.w_we = 1'b1; bus.w_a = 4'd10; bus.w_d = 8'h20;
    for (int i = 0; i < 6; i++) begin
      run_cycle(fg, wg);
      check("alt_fs", 32'(obs_fs), 32'(i % 2 == 0));
      check("alt_ws", 32'(obs_ws), 32'(i % 2 == 1));
      if (fg) bus.f_a = bus.f_a + 4'd1;
      if (wg) begin
        bus.w_a = bus.w_a + 4'd1;
        bus.w_d = DW'($urandom);
      end
    end

    // same-address collision forwards write data
    bus.f_a = 4'd9;
    bus.w_a = 4'd9; bus.w_d = 8'hA5;
    run_cycle(fg, wg);
    check("fwd_fd", 32'(obs_fd), 32'hA5);
    check("fwd_fs", 32'(obs_fs), 32'd0);
    check("fwd_ws", 32'(obs_ws), 32'd0);
    bus.w_we = 1'b0;
    run_cycle(fg, wg);
    check("rd9", 32'(obs_fd), 32'hA5);

    // randomized traffic; stalled requesters hold their request
    for (int n = 0; n < 400; n++) begin
      run_cycle(fg, wg);
      if (!bus.f_ce || fg) begin
        bus.f_ce = ($urandom % 4) != 0;
        bus.f_a  = AW'($urandom);
      end
      if (!bus.w_we || wg) begin
        bus.w_we = ($urandom % 2) != 0;
        bus.w_a  = (($urandom % 3) == 0) ? bus.f_a : AW'($urandom);
        bus.w_d  = DW'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++)
      check("ram_final", 32'(ram[i]), 32'(ref_mem[i]));
    @(posedge clk); #1;

    // reset pulsed at sweep address 6 restarts the sweep
    bus.f_ce = 1'b1;
    bus.w_we = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("pre_a", 32'(bus.m_a), 32'(i));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_we", 32'(bus.m_we), 32'd0);
    check("mid_rdy", 32'(ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
